int_cont_bank: RTL and testbench

Parametrised interrupt control register bank for the LVDA: `NCH` inhibit bits, each set or cleared by a decoded PIO command during the V1 phase, plus per-channel edge-detected pending latches. It also provides a registered lowest-index-first priority encoder and a CPU acknowledge path. It generalises the fixed 13-bit interrupt control register by adding:
- a parametrised channel count;
- bulk write;
- pending/acknowledge behaviour, which was previously external.

---
 rtl/int_cont_bank.sv | 145 ++++++++++++++
 tb/tb_int_cont_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/int_cont_bank.sv
// ---------------------------------------------------------------------------
// int_cont_bank
// Interrupt control register bank for the LVDA.
//   - NCH inhibit bits (1 = inhibited), modified by PIO commands accepted
//     only while the V1 phase strobe is high (set bit / clear bit /
//     write all / no-op).
//   - Per-channel rising-edge detectors feeding pending latches, with a
//     CPU acknowledge that clears one pending bit.
//   - Registered lowest-index-first priority encoder over pending & ~icr.
//
// Ports:
//   SIM_CLK    clock; all state changes on its rising edge
//   SIM_RST    asynchronous active-low reset
//   V1         phase strobe; commands are accepted only while it is high
//   cmd_valid  command request, held by the requester until accepted
//   cmd_op     00 set, 01 clear, 10 write all, 11 no-op
//   cmd_sel    channel index for set/clear
//   cmd_data   value for write all
//   cmd_ready  combinational, equal to V1
//   int_src    raw interrupt sources (synchronous to SIM_CLK)
//   ack        single-cycle acknowledge pulse
//   ack_num    channel being acknowledged
//   icr        inhibit register
//   icr_n      complement of icr
//   pending    pending latches
//   int_out    registered: any unmasked channel pending
//   int_num    registered: lowest unmasked pending index, 0 when idle
// ---------------------------------------------------------------------------
module int_cont_bank #(
    parameter int               NCH     = 13,
    parameter int               IW      = 5,
    parameter logic [NCH-1:0]   RST_ICR = '1
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            V1,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_op,
    input  logic [IW-1:0]   cmd_sel,
    input  logic [NCH-1:0]  cmd_data,
    output logic            cmd_ready,
    input  logic [NCH-1:0]  int_src,
    input  logic            ack,
    input  logic [IW-1:0]   ack_num,
    output logic [NCH-1:0]  icr,
    output logic [NCH-1:0]  icr_n,
    output logic [NCH-1:0]  pending,
    output logic            int_out,
    output logic [IW-1:0]   int_num
);

    logic [NCH-1:0] icr_q, icr_d;
    logic [NCH-1:0] src_q, src_d;
    logic [NCH-1:0] pending_q, pending_d;
    logic           int_out_q, int_out_d;
    logic [IW-1:0]  int_num_q, int_num_d;

    logic [NCH-1:0] sel_mask_s;
    logic [NCH-1:0] ack_mask_s;
    logic [NCH-1:0] edge_s;
    logic [NCH-1:0] active_s;
    logic           cmd_acc_s;

    // Command handshake: a request is taken on any V1 cycle.
    always_comb begin
        cmd_ready = V1;
        cmd_acc_s = cmd_valid & V1;
    end

    // One-hot decodes of cmd_sel and ack_num; indices >= NCH decode to zero,
    // which turns out-of-range set/clear/ack into harmless no-ops.
    always_comb begin
        sel_mask_s = '0;
        ack_mask_s = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_mask_s[i] = (cmd_sel == IW'(i));
            ack_mask_s[i] = ack & (ack_num == IW'(i));
        end
    end

    // Inhibit register next state.
    always_comb begin
        icr_d = icr_q;
        if (cmd_acc_s) begin
            case (cmd_op)
                2'b00:   icr_d = icr_q | sel_mask_s;
                2'b01:   icr_d = icr_q & ~sel_mask_s;
                2'b10:   icr_d = cmd_data;
                default: icr_d = icr_q;
            endcase
        end else begin
            icr_d = icr_q;
        end
    end

    // Edge detection and pending latches; a fresh edge overrides an ack on
    // the same channel because the OR is applied after the ack clear.
    always_comb begin
        src_d     = int_src;
        edge_s    = int_src & ~src_q;
        pending_d = (pending_q & ~ack_mask_s) | edge_s;
    end

    // Lowest-index-first priority encoder over unmasked pending bits; the
    // downward scan lets the lowest set index be the last one written.
    always_comb begin
        active_s  = pending_q & ~icr_q;
        int_out_d = |active_s;
        int_num_d = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (active_s[i]) begin
                int_num_d = IW'(i);
            end else begin
                int_num_d = int_num_d;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            icr_q     <= RST_ICR;
            src_q     <= '0;
            pending_q <= '0;
            int_out_q <= 1'b0;
            int_num_q <= '0;
        end else begin
            icr_q     <= icr_d;
            src_q     <= src_d;
            pending_q <= pending_d;
            int_out_q <= int_out_d;
            int_num_q <= int_num_d;
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        icr     = icr_q;
        icr_n   = ~icr_q;
        pending = pending_q;
        int_out = int_out_q;
        int_num = int_num_q;
    end

endmodule

// File: tb/tb_int_cont_bank.sv
// ---------------------------------------------------------------------------
// tb_int_cont_bank
// Directed self-checking bench for int_cont_bank with NCH=13, IW=5.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled
// 1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_int_cont_bank;

    logic        clk;
    logic        rst_n;
    logic        v1;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_sel;
    logic [12:0] cmd_data;
    logic        cmd_ready;
    logic [12:0] int_src;
    logic        ack;
    logic [4:0]  ack_num;
    logic [12:0] icr;
    logic [12:0] icr_n;
    logic [12:0] pending;
    logic        int_out;
    logic [4:0]  int_num;

    int n_assert = 0;
    int n_fail   = 0;

    int_cont_bank #(.NCH(13), .IW(5), .RST_ICR(13'h1FFF)) dut (
        .SIM_CLK   (clk),
        .SIM_RST   (rst_n),
        .V1        (v1),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .int_src   (int_src),
        .ack       (ack),
        .ack_num   (ack_num),
        .icr       (icr),
        .icr_n     (icr_n),
        .pending   (pending),
        .int_out   (int_out),
        .int_num   (int_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_icr"},     32'(icr),     32'h1FFF);
        chk({tag, "_icr_n"},   32'(icr_n),   32'h0000);
        chk({tag, "_pending"}, 32'(pending), 32'h0000);
        chk({tag, "_int_out"}, 32'(int_out), 32'h0);
        chk({tag, "_int_num"}, 32'(int_num), 32'h0);
    endtask

    initial begin
        rst_n     = 1'b1;
        v1        = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b11;
        cmd_sel   = 5'd0;
        cmd_data  = 13'h0000;
        int_src   = 13'h0000;
        ack       = 1'b0;
        ack_num   = 5'd0;
        #1 rst_n = 1'b0;
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Command held while V1 is low: no effect.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 5'd4;
        chk("ready_low", 32'(cmd_ready), 32'h0);
        step(); step(); step();
        chk("v1_low_hold", 32'(icr), 32'h1FFF);

        v1 = 1'b1;
        #1 chk("ready_high", 32'(cmd_ready), 32'h1);
        step();
        chk("clear4", 32'(icr), 32'h1FEF);
        chk("clear4_n", 32'(icr_n), 32'h0010);
        cmd_op = 2'b00;
        step();
        chk("set4", 32'(icr), 32'h1FFF);
        cmd_op = 2'b10; cmd_data = 13'h0A5A;
        step();
        chk("write_all", 32'(icr), 32'h0A5A);
        chk("write_all_n", 32'(icr_n), 32'h15A5);
        cmd_op = 2'b01; cmd_sel = 5'd20;
        step();
        chk("clear20", 32'(icr), 32'h0A5A);
        cmd_op = 2'b11;
        step();
        chk("noop", 32'(icr), 32'h0A5A);
        cmd_op = 2'b10; cmd_data = 13'h0000;
        step();
        chk("write_zero", 32'(icr), 32'h0000);
        cmd_valid = 1'b0;

        // Two sources rise together and stay high.
        int_src = 13'h0084;
        step();
        chk("edge_pending", 32'(pending), 32'h0084);
        chk("edge_int_out_lag", 32'(int_out), 32'h0);
        step();
        chk("no_retrigger", 32'(pending), 32'h0084);
        chk("int_out_2", 32'(int_out), 32'h1);
        chk("int_num_2", 32'(int_num), 32'd2);
        ack = 1'b1; ack_num = 5'd2;
        step();
        ack = 1'b0;
        chk("ack2_pending", 32'(pending), 32'h0080);
        chk("ack2_stale_num", 32'(int_num), 32'd2);
        step();
        chk("int_num_7", 32'(int_num), 32'd7);
        chk("int_out_7", 32'(int_out), 32'h1);
        ack = 1'b1; ack_num = 5'd7;
        step();
        ack = 1'b0;
        chk("ack7_pending", 32'(pending), 32'h0000);
        step();
        chk("ack7_int_out", 32'(int_out), 32'h0);
        chk("ack7_int_num", 32'(int_num), 32'd0);
        int_src = 13'h0000;

        // Masked channel latches pending but does not interrupt.
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 13'h1FFF;
        step();
        cmd_valid = 1'b0;
        chk("mask_all", 32'(icr), 32'h1FFF);
        int_src = 13'h0200;
        step();
        int_src = 13'h0000;
        chk("masked_pending", 32'(pending), 32'h0200);
        step();
        chk("masked_int_out", 32'(int_out), 32'h0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 5'd9;
        step();
        cmd_valid = 1'b0;
        chk("unmask9_icr", 32'(icr), 32'h1DFF);
        chk("unmask9_lag", 32'(int_out), 32'h0);
        step();
        chk("unmask9_int_out", 32'(int_out), 32'h1);
        chk("unmask9_int_num", 32'(int_num), 32'd9);

        // Edge beats ack on the same channel in the same cycle.
        int_src = 13'h0008;
        step();
        chk("pend3_set", 32'(pending), 32'h0208);
        int_src = 13'h0000;
        step();
        int_src = 13'h0008; ack = 1'b1; ack_num = 5'd3;
        step();
        ack = 1'b0;
        chk("edge_beats_ack", 32'(pending), 32'h0208);
        ack = 1'b1; ack_num = 5'd15;
        step();
        ack = 1'b0;
        chk("ack_out_of_range", 32'(pending), 32'h0208);

        // Fill all pending bits, then reset asynchronously mid-cycle.
        int_src = 13'h0000;
        step();
        int_src = 13'h1FFF;
        step();
        chk("pending_full", 32'(pending), 32'h1FFF);
        int_src = 13'h0001;
        step();
        chk("pre_reset_int_out", 32'(int_out), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_edge", 32'(pending), 32'h0001);
        step();
        chk("post_reset_masked", 32'(int_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
